// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline-control types and default sizes
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam int CNT_W_DEF       = 16;
    localparam int MEM_TIMEOUT_DEF = 64;
    localparam int REG_IDX_W       = 5;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, holds at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, branch flush and memory-freeze control
module hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] if_id_rs1,
    input  logic [REG_IDX_W-1:0] if_id_rs2,
    input  logic                 id_ex_MemRead,
    input  logic [REG_IDX_W-1:0] id_ex_rd,
    input  logic                 ex_branch_taken,
    input  logic                 ex_mem_MemRead,
    input  logic                 ex_mem_MemWrite,
    input  logic                 dmem_ready,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 id_ex_write,
    output logic                 ex_mem_write,
    output logic                 if_id_flush,
    output logic                 id_ex_bubble,
    output logic                 mem_wb_bubble,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic [CNT_W-1:0]     freeze_cnt,
    output logic                 mem_err
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              r_mem_err;
    logic              w_mem_err_nxt;

    logic w_freeze;
    logic w_load_use;
    logic w_do_freeze;
    logic w_do_flush;
    logic w_do_stall;

    assign w_freeze   = (ex_mem_MemRead | ex_mem_MemWrite) & ~dmem_ready;
    assign w_load_use = id_ex_MemRead && (id_ex_rd != '0) &&
                        ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

    // Exactly one winner per cycle; reset suppresses all of them.
    assign w_do_freeze = ~reset & w_freeze;
    assign w_do_flush  = ~reset & ~w_freeze & ex_branch_taken;
    assign w_do_stall  = ~reset & ~w_freeze & ~ex_branch_taken & w_load_use;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_mem_err  <= w_mem_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = ST_RUN;
        w_wait_nxt    = '0;
        w_mem_err_nxt = r_mem_err;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;

        if (w_freeze) begin
            w_state_nxt = ST_MEM_WAIT;
            if (r_state == ST_RUN) begin
                w_wait_nxt = WAIT_W'(1);
            end else begin
                w_wait_nxt = (r_wait_cnt == WAIT_SAT) ? WAIT_SAT : r_wait_cnt + 1'b1;
                if (r_wait_cnt == WAIT_LAST) begin
                    w_mem_err_nxt = 1'b1;
                end
            end
        end

        if (w_do_freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (w_do_flush) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (w_do_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    assign mem_err = r_mem_err;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_do_stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_do_flush),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_do_freeze),
        .count (freeze_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed scoreboard bench for hazard_unit
module tb_hazard_unit;

    localparam int CW = 3;
    localparam int TO = 4;

    localparam logic [6:0] C_DEF = 7'b1111_000;
    localparam logic [6:0] C_FRZ = 7'b0000_001;
    localparam logic [6:0] C_BR  = 7'b1111_110;
    localparam logic [6:0] C_LU  = 7'b0011_010;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    if_id_rs1, if_id_rs2, id_ex_rd;
    logic          id_ex_MemRead, ex_branch_taken;
    logic          ex_mem_MemRead, ex_mem_MemWrite, dmem_ready;
    logic          pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic          if_id_flush, id_ex_bubble, mem_wb_bubble;
    logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;
    logic          mem_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [6:0]  ctrl;
        logic [10:0] regs;
    } exp_t;
    exp_t sb[$];

    logic [CW-1:0] m_stall = '0, m_flush = '0, m_freeze = '0;
    logic          m_err = 1'b0;
    logic          m_state = 1'b0;
    int            m_wait = 0;

    hazard_unit #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .if_id_rs1       (if_id_rs1),
        .if_id_rs2       (if_id_rs2),
        .id_ex_MemRead   (id_ex_MemRead),
        .id_ex_rd        (id_ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .ex_mem_MemRead  (ex_mem_MemRead),
        .ex_mem_MemWrite (ex_mem_MemWrite),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_write     (id_ex_write),
        .ex_mem_write    (ex_mem_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .mem_wb_bubble   (mem_wb_bubble),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .freeze_cnt      (freeze_cnt),
        .mem_err         (mem_err)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic mr,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic br, input logic emr, input logic emw, input logic rdy);
        exp_t e;
        logic fz, lu;
        reset = rst; id_ex_MemRead = mr; id_ex_rd = rd; if_id_rs1 = rs1; if_id_rs2 = rs2;
        ex_branch_taken = br; ex_mem_MemRead = emr; ex_mem_MemWrite = emw; dmem_ready = rdy;
        fz = (emr | emw) & ~rdy;
        lu = mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
        if (rst) begin
            e.ctrl = C_DEF;
            m_stall = '0; m_flush = '0; m_freeze = '0; m_err = 1'b0; m_state = 1'b0; m_wait = 0;
        end else if (fz) begin
            e.ctrl = C_FRZ;
            m_freeze = sat_inc(m_freeze);
            if (!m_state) begin
                m_state = 1'b1; m_wait = 1;
            end else begin
                if (m_wait == TO - 1) m_err = 1'b1;
                if (m_wait < TO) m_wait++;
            end
        end else begin
            if (br) begin
                e.ctrl = C_BR; m_flush = sat_inc(m_flush);
            end else if (lu) begin
                e.ctrl = C_LU; m_stall = sat_inc(m_stall);
            end else begin
                e.ctrl = C_DEF;
            end
            m_state = 1'b0; m_wait = 0;
        end
        e.tag  = tag;
        e.regs = {m_stall, m_flush, m_freeze, m_err, m_state};
        sb.push_back(e);

        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        assert ({pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_bubble,
                 mem_wb_bubble} === e.ctrl) else begin
            n_errors++;
            $error("FAIL %s_ctrl: observed %b expected %b", e.tag,
                   {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_bubble,
                    mem_wb_bubble}, e.ctrl);
        end
        @(posedge clk);
        #1;
        n_checks++;
        assert ({stall_cnt, flush_cnt, freeze_cnt, mem_err, dut.r_state} === e.regs) else begin
            n_errors++;
            $error("FAIL %s_regs: observed %h expected %h", e.tag,
                   {stall_cnt, flush_cnt, freeze_cnt, mem_err, dut.r_state}, e.regs);
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; id_ex_MemRead = 1'b0; id_ex_rd = '0; if_id_rs1 = '0; if_id_rs2 = '0;
        ex_branch_taken = 1'b0; ex_mem_MemRead = 1'b0; ex_mem_MemWrite = 1'b0; dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        step("reset", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_stall_cnt", 16'(stall_cnt), 16'd0);
        chk("reset_mem_err", 16'(mem_err), 16'd0);
        idle("idle0");

        step("lu_rs2", 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_stall_cnt", 16'(stall_cnt), 16'd1);
        step("x0", 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("x0_stall_cnt", 16'(stall_cnt), 16'd1);
        step("lu_rs1", 1'b0, 1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step("no_load", 1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        step("br_over_lu", 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("br_flush_cnt", 16'(flush_cnt), 16'd1);
        chk("br_stall_cnt", 16'(stall_cnt), 16'd2);

        for (int i = 0; i < 3; i++)
            step("frz_br", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("frz_ready", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("frz_freeze_cnt", 16'(freeze_cnt), 16'd3);
        chk("frz_flush_cnt", 16'(flush_cnt), 16'd2);
        chk("frz_mem_err", 16'(mem_err), 16'd0);

        step("single_cycle", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("frz_lu", 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("frz_lu_rdy", 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("frz_lu_stall_cnt", 16'(stall_cnt), 16'd3);

        for (int i = 0; i < 6; i++)
            step("stall_sat", 1'b0, 1'b1, 5'd4, 5'd4, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_saturated", 16'(stall_cnt), 16'd7);

        for (int i = 0; i < 6; i++)
            step("timeout", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("timeout_rdy", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle("after_timeout");
        chk("timeout_sticky", 16'(mem_err), 16'd1);
        chk("freeze_saturated", 16'(freeze_cnt), 16'd7);
        step("clr_err", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_clears_err", 16'(mem_err), 16'd0);

        step("wait_c1", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("wait_c2_rst", 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_mid_wait_freeze_cnt", 16'(freeze_cnt), 16'd0);
        step("wait_again", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("wait_done", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage core. It is the stall/flush counterpart of `forwarding_unit`: it handles the hazards that forwarding cannot resolve and drives the pipeline-register write enables, bubbles and flushes. It covers three cases: load-use stalls, taken-branch flushes, and full-pipeline freeze while a variable-latency data memory access is outstanding. It also keeps saturating performance counters and a sticky memory-timeout error.

## Interface
Parameters:
- `CNT_W`, 16, width of each performance counter.
- `MEM_TIMEOUT`, 64, number of freeze cycles for a single access before `mem_err` sets (≥2).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `if_id_rs1`, `if_id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_ex_MemRead`  in  1  instruction in EX is a load.
- `id_ex_rd`  in  5  destination register of the instruction in EX.
- `ex_branch_taken`  in  1  branch resolved taken in EX this cycle.
- `ex_mem_MemRead`, `ex_mem_MemWrite`  in  1 each  MEM-stage access in progress.
- `dmem_ready`  in  1  data memory completes the MEM-stage access this cycle.
- `pc_write`  out  1  PC update enable.
- `if_id_write`  out  1  IF/ID register enable.
- `id_ex_write`, `ex_mem_write`  out  1 each  ID/EX and EX/MEM register enables.
- `if_id_flush`  out  1  zero IF/ID (NOP).
- `id_ex_bubble`  out  1  zero ID/EX control signals.
- `mem_wb_bubble`  out  1  zero MEM/WB control signals (no writeback).
- `stall_cnt`, `flush_cnt`, `freeze_cnt`  out  CNT_W each  saturating counters.
- `mem_err`  out  1  sticky access-timeout flag.

## Operation
Control outputs are combinational (Mealy) functions of the current state and inputs. The state, the wait counter, the performance counters and `mem_err` are registered.

Hazard conditions:
- freeze = (`ex_mem_MemRead` | `ex_mem_MemWrite`) & !`dmem_ready`.
- load_use = `id_ex_MemRead` & (`id_ex_rd` != 0) & (`id_ex_rd` == `if_id_rs1` | `id_ex_rd` == `if_id_rs2`). This is conservative: it also fires when the instruction in ID does not actually use rs2.

Priority is freeze > branch > load_use. Outputs for each case:
- **Default:** all write enables 1; all flush/bubble outputs 0.
- **Freeze:**
  - `pc_write`, `if_id_write`, `id_ex_write`, `ex_mem_write` = 0.
  - `mem_wb_bubble` = 1.
  - Branch and load-use are suppressed. They are acted on once the pipeline unfreezes, because their inputs are held.
- **Branch (not freeze):**
  - `if_id_flush` = 1 and `id_ex_bubble` = 1.
  - `pc_write` = 1, so the PC loads the branch target.
  - Load-use is ignored, because the dependent instruction is being squashed.
- **Load_use (neither of the above):**
  - `pc_write` = 0, `if_id_write` = 0, `id_ex_bubble` = 1.
  - Lasts exactly one cycle: after the bubble, `id_ex_MemRead` is 0.

State machine (states RUN, MEM_WAIT):
- RUN: if freeze, go to MEM_WAIT with `wait_cnt` = 1; otherwise stay in RUN.
- MEM_WAIT, freeze still true: stay in MEM_WAIT. `wait_cnt` increments and saturates at MEM_TIMEOUT.
- MEM_WAIT, `dmem_ready` = 1: freeze is deasserted that same cycle, the pipeline advances, and the next state is RUN with `wait_cnt` = 0.
- The freeze outputs depend only on the freeze condition, not on the state. The state exists only for timeout tracking.
- `mem_err`: set at the edge where a still-frozen MEM_WAIT cycle has `wait_cnt` == MEM_TIMEOUT−1. It stays set until reset. The pipeline remains frozen while `mem_err` is set; there is no auto-abort.

Counters:
- Each counter increments by 1 at the clock edge that closes a cycle in which its condition was the active (winning) one:
  - `stall_cnt`: load_use.
  - `flush_cnt`: branch.
  - `freeze_cnt`: freeze.
- Each counter holds at 2^CNT_W−1 (saturates, no wrap).

## Timing
- Zero-cycle latency from inputs to control outputs. There is no register on the control path.
- Reset value of every registered item: state RUN, `wait_cnt` 0, all counters 0, `mem_err` 0.
- While `reset` = 1, outputs are forced to the default values: enables 1, flush/bubble 0.
- Reset asserted mid-MEM_WAIT: the next edge gives RUN and clears all counters and `mem_err`.
- A freeze with `dmem_ready` high in the same cycle as the access (single-cycle memory) causes no freeze and no state change.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the state encoding (RUN = 1'b0, MEM_WAIT = 1'b1);
  - the default values of `CNT_W` and `MEM_TIMEOUT`;
  - the register-index width constant (5).
- Sub-module `sat_counter` (parameters `W`; ports `clk`, `reset`, `inc`, `count`) is instantiated three times for the performance counters.

## Test plan
1. **Load-use stall:** `id_ex_MemRead`=1, `id_ex_rd`=5, `if_id_rs2`=5 for one cycle → `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1 in that cycle; `stall_cnt` goes 0→1.
2. **x0 exclusion:** `id_ex_MemRead`=1, `id_ex_rd`=0, `if_id_rs1`=0 → default outputs; `stall_cnt` stays 0.
3. **Branch wins over load-use:** `ex_branch_taken`=1 together with the case 1 inputs → `if_id_flush`=1, `id_ex_bubble`=1, `pc_write`=1; `flush_cnt`=1, `stall_cnt`=0.
4. **Memory wait:** `ex_mem_MemRead`=1, `dmem_ready` low for 3 cycles, then high → all four enables 0 and `mem_wb_bubble`=1 for exactly 3 cycles; `freeze_cnt`=3; state back in RUN; `mem_err`=0. A branch held during the freeze produces its flush only in the ready cycle.
5. **Timeout:** `MEM_TIMEOUT`=4, `dmem_ready` held low for 6 cycles → `mem_err` rises after the 4th freeze cycle and stays 1 after `dmem_ready` returns; `reset` clears it.
6. **Reset mid-wait:** `reset` pulsed during cycle 2 of a MEM_WAIT → next cycle state is RUN, all counters 0, outputs at defaults while `reset` is high.
